// File: rtl/mips_pkg.sv
// Shared widths, reset defaults and the fetch-buffer entry type used by
// the fetch front end and decode.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; head is read combinationally
// so an entry written at an edge is visible from that edge onward.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq,
  input  logic          deq,
  input  fetch_entry_t  wdata,
  output logic          full,
  output logic          empty,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  // Storage is cleared on reset so the outputs read zero before any fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (enq) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (enq && !deq) begin
        r_count <= r_count + CW'(1);
      end else if (!enq && deq) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, reads the async ROM, buffers
// {pc, instr} pairs for decode and services branch/jump redirects.
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic              r_primed;

  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  fetch_entry_t      w_wdata;
  fetch_entry_t      w_head;
  logic [CW-1:0]     w_unused_count;
  logic              w_unused_redirect_lo;

  assign w_unused_redirect_lo = ^redirect_pc[1:0];

  assign imem_addr = r_pc;
  assign w_deq     = ~w_empty & out_ready;
  assign w_enq     = fetch_en & ~redirect_valid & (~w_full | w_deq);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_data;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .enq  (w_enq),
    .deq  (w_deq),
    .wdata(w_wdata),
    .full (w_full),
    .empty(w_empty),
    .head (w_head),
    .count(w_unused_count)
  );

  assign out_valid = ~w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  // The zeroed head would otherwise show pc+4 = 4 straight out of reset.
  assign out_pc_plus4 = r_primed ? (w_head.pc + ADDR_W'(4)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_primed <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (w_enq) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      if (w_enq) begin
        r_primed <= 1'b1;
      end
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end and initiator side of the instruction-memory read interface.
- Owns the PC, drives the word address into the asynchronous instruction ROM, and captures the returned word in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirect requests from branch/jump resolution by flushing the buffer and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction ROM; always equal to the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- fetch_en  in  1  1 = fetch allowed; 0 = freeze the PC and stop enqueuing.
- redirect_valid  in  1  redirect request (taken branch/jump).
- redirect_pc  in  32  redirect target address.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.

Behaviour:
- Reset, asserted asynchronously on rst_n=0:
  - pc = RESET_PC, FIFO empty, count = 0.
  - out_valid = 0; out_instr, out_pc and out_pc_plus4 read 0.
  - Mid-operation reset discards all buffered entries immediately.
- imem_addr = pc, combinational from the PC register.
- deq = out_valid & out_ready.
- enq = fetch_en & ~redirect_valid & (count < DEPTH | deq).
- On enq: write {pc, imem_data} at the tail; pc <= pc + 4, wrapping 32'hFFFF_FFFC → 0.
- On deq: advance the head pointer.
- Enqueue and dequeue in the same cycle leave count unchanged and are legal when full.
- Full (count = DEPTH) and no deq: no enqueue, pc holds, imem_addr stable.
- Empty: out_valid = 0; out_* hold their last values (don't-care).
- Latency: an instruction fetched at edge N is visible on out_* from edge N onward, i.e. one cycle after imem_addr presented it. First valid output appears one cycle after reset release.
- Throughput: one instruction per cycle while out_ready = 1 and fetch_en = 1.
- Redirect (redirect_valid = 1 at an edge), highest priority:
  - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - FIFO flushed: count = 0, pointers reset.
  - No enqueue that cycle.
  - A deq in the same cycle still counts as a completed transfer; all other entries are discarded.
  - out_valid = 0 the cycle after a redirect. The target instruction appears the following cycle if fetch_en = 1.
- Back-to-back redirects: the last one wins; out_valid stays 0.
- fetch_en = 0: pc holds and no enqueue; dequeue continues, so the buffer drains. Redirect still applies.
- Stability rule: while out_valid = 1 and out_ready = 0, out_instr and out_pc must not change unless a redirect or reset occurs.
- Counters: pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH+1) bits.

Decomposition:
- Shared package mips_pkg:
  - INSTR_W = 32, ADDR_W = 32.
  - Default RESET_PC.
  - A fetch_entry_t struct {pc, instr} used by the FIFO and by decode.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t.
  - Ports: clk, rst_n, flush, enq, deq.
  - Outputs: full, empty, head, count.
- if_fetch holds the PC register and the enq/deq/redirect control only.

Test Plan:
- Streaming: ROM[k] = 32'h1000_0000 + k, reset released, out_ready = 1. Response: out_valid from cycle 1; out_pc 0, 4, 8, … with out_instr 32'h1000_0000, 1000_0001, … one per cycle.
- Backpressure: out_ready = 0 for 5 cycles after the first valid. Response: count saturates at 2; imem_addr holds at 32'h8; out_pc stays 0. Releasing out_ready delivers 0, 4, 8 with no gaps or duplicates.
- Redirect with handshake: redirect_valid = 1 with redirect_pc = 32'h40 while out_pc = 32'h4 is being accepted. Response: the 0x4 transfer counts; out_valid = 0 next cycle; then out_pc = 32'h40 with ROM[16].
- Misaligned redirect: redirect_pc = 32'h23 → next fetched out_pc = 32'h20.
- fetch_en = 0 for 3 cycles with out_ready = 1. Response: buffer drains to out_valid = 0, imem_addr frozen. Re-enabling resumes at the frozen PC with no skipped address.
- Reset mid-stream: rst_n = 0 asynchronously while full. Response: out_valid = 0 without waiting for a clock edge; after release, out_pc sequence restarts at RESET_PC.
